uword_sequencer: RTL
====================

# uword_sequencer

Parametrised microcode sequencer that drives the SPARC datapath control word (register enables, mux selects, MFA, and similar signals) from a writable control store. It replaces hand-sequenced control stimulus with stored microprograms. It waits on the memory handshake (MFA/MFC), dispatches on the instruction opcode field, and traps to a fault routine on memory timeout. It sits between the instruction decode logic and the datapath control inputs.

## Interface
Parameters:
- CW_WIDTH, 48, width of the datapath control field driven on CW
- ADDR_W, 6, control-store address width; depth = 2**ADDR_W
- OP_W, 6, width of the opcode used for dispatch
- DISP_BASE, 32, control-store address added to the opcode on dispatch
- WAIT_MAX, 15, maximum cycles spent in a WAIT micro-op before a fault is taken (1..255)
- FAULT_ADDR, 63, microaddress jumped to on memory timeout

Microword layout, MW = CW_WIDTH+2+ADDR_W bits: [CW_WIDTH-1:0] control; [CW_WIDTH+1:CW_WIDTH] cond; [MW-1:CW_WIDTH+2] target.

Ports:
- Clk  in  1  clock; all state changes on the rising edge
- Clr  in  1  reset, synchronous, active-high
- run  in  1  level; 1 = sequencer may advance, 0 = hold
- ld_en  in  1  control-store write strobe
- ld_addr  in  ADDR_W  control-store write address
- ld_data  in  MW  microword to write
- OP1  in  OP_W  opcode used by DISPATCH
- MFC  in  1  memory function complete
- CW  out  CW_WIDTH  registered control word to the datapath
- uPC  out  ADDR_W  registered current microaddress
- busy  out  1  1 when the state is not IDLE
- mem_timeout  out  1  sticky fault flag; cleared only by Clr

## Operation
- States: IDLE, RUN, WAIT, FAULT.
- Reset (Clr=1 at an edge): state=IDLE, uPC=0, CW=0, busy=0, mem_timeout=0, wait counter=0. Control-store contents are not reset.
- IDLE: when run=1, go to RUN with uPC=0 and CW=store[0].control.
- RUN/WAIT: the next address is selected by cond of the current word:
  - 0 SEQ: uPC+1, wrapping modulo 2**ADDR_W.
  - 1 JUMP: target.
  - 2 WAITMFC: hold uPC and CW while MFC=0, with the state in WAIT. On the first cycle MFC=1, advance to uPC+1.
  - 3 DISPATCH: (DISP_BASE + OP1) truncated to ADDR_W bits.
- Every advance loads uPC and CW = store[next].control in the same edge.
- run=0 in RUN or WAIT: hold uPC, CW and the wait counter; the state is unchanged. The MFC check is also suspended.
- Wait counter: increments each held WAIT cycle. If it reaches WAIT_MAX with MFC still 0, the sequencer goes to FAULT:
  - uPC=FAULT_ADDR, CW=store[FAULT_ADDR].control, mem_timeout=1.
  - The counter clears on any exit from WAIT.
- FAULT: executes like RUN from FAULT_ADDR, with mem_timeout held at 1.
- A JUMP to the word's own address is a legal halt loop.
- Control-store write: on an edge with ld_en=1, store[ld_addr] <= ld_data.
- If the same edge also fetches ld_addr, CW takes the old contents; the new word is visible from the next fetch.
- Clr has priority over run, ld_en and MFC.

## Timing
- Latency: the word written at uPC appears on CW in the same cycle as uPC; there is one edge from the decision to the change.
- IDLE->first CW: one edge after run is first sampled at 1.
- WAITMFC with MFC=1 already present on entry: holds exactly one cycle, then advances.
- Timeout: with MFC stuck at 0, the fault entry occurs WAIT_MAX edges after WAIT is entered.
- MFC rising on the same edge the counter reaches WAIT_MAX: MFC wins; the sequencer advances normally and no fault is taken.
- Clr asserted mid-WAIT or mid-FAULT: the next edge gives state IDLE, CW=0, mem_timeout=0.

## Test plan
- Reset: Clr=1 for 2 cycles with run=1 -> CW=0, uPC=0, busy=0, mem_timeout=0. Release Clr -> next edge uPC=0, CW=store[0].control.
- Sequence/jump: store[0..2] SEQ with control 0x1,0x2,0x3; store[3] JUMP target 0 -> CW cycles 1,2,3,<w3>,1; uPC follows 0,1,2,3,0. Also check 63 SEQ -> 0 wrap.
- MFC handshake: store[1]=WAITMFC. Assert MFC 4 cycles after entry -> uPC=1 for 5 cycles, then 2; mem_timeout stays 0.
- Timeout: WAIT_MAX=15 with MFC held 0 -> after 15 edges uPC=63, CW=store[63].control, mem_timeout=1 and sticky until Clr. Also cover MFC=1 on the 15th edge -> no fault.
- Dispatch: OP1=6'b001000, DISP_BASE=32 -> uPC=40. Also OP1=6'h3F -> (32+63) mod 64 = 31.
- Hold/write collision: run=0 for 3 cycles mid-program -> uPC and CW frozen. Write ld_addr=5 on the same edge that fetches 5 -> old CW; the next fetch of 5 shows the new word.

Source files
------------

// File: rtl/uword_sequencer.sv
// Microcode sequencer: steps a writable control store and drives the registered datapath control word.
// Supports sequential, jump, MFC-wait with timeout-to-fault, and opcode dispatch next-address modes.
module uword_sequencer #(
    parameter int CW_WIDTH   = 48,
    parameter int ADDR_W     = 6,
    parameter int OP_W       = 6,
    parameter int DISP_BASE  = 32,
    parameter int WAIT_MAX   = 15,
    parameter int FAULT_ADDR = 63,
    localparam int MW        = CW_WIDTH + 2 + ADDR_W
) (
    input  logic                Clk,
    input  logic                Clr,
    input  logic                run,
    input  logic                ld_en,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [MW-1:0]       ld_data,
    input  logic [OP_W-1:0]     OP1,
    input  logic                MFC,
    output logic [CW_WIDTH-1:0] CW,
    output logic [ADDR_W-1:0]   uPC,
    output logic                busy,
    output logic                mem_timeout
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] C_SEQ      = 2'd0;
    localparam logic [1:0] C_JUMP     = 2'd1;
    localparam logic [1:0] C_WAITMFC  = 2'd2;
    localparam logic [1:0] C_DISPATCH = 2'd3;

    localparam logic [ADDR_W-1:0] DISP_A  = ADDR_W'(DISP_BASE);
    localparam logic [ADDR_W-1:0] FAULT_A = ADDR_W'(FAULT_ADDR);
    localparam logic [7:0]        WMAX    = 8'(WAIT_MAX);

    // state | meaning: IDLE idle/reset | RUN executing | WAIT held on MFC | FAULT executing fault routine
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_FAULT} state_t;

    logic [MW-1:0] store [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] upc_q, upc_d;
    logic [MW-1:0]     mw_q, mw_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic              tout_q, tout_d;

    logic [1:0]        cond;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] nxt;
    logic [7:0]        wcnt_inc;
    logic              advance;

    always_comb begin
        cond     = mw_q[CW_WIDTH+1:CW_WIDTH];
        target   = mw_q[MW-1:CW_WIDTH+2];
        wcnt_inc = wcnt_q + 8'd1;
        state_d  = state_q;
        upc_d    = upc_q;
        mw_d     = mw_q;
        wcnt_d   = wcnt_q;
        tout_d   = tout_q;
        advance  = 1'b0;

        case (cond)
            C_JUMP:     nxt = target;
            C_DISPATCH: nxt = DISP_A + ADDR_W'(OP1);
            default:    nxt = upc_q + ADDR_W'(1);
        endcase

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_RUN;
                    nxt     = '0;
                    advance = 1'b1;
                end
            end
            S_RUN, S_FAULT: begin
                if (run) begin
                    if (cond == C_WAITMFC && !MFC) begin
                        state_d = S_WAIT;
                        wcnt_d  = '0;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // MFC takes priority over a timeout reached on the same edge
                if (run) begin
                    if (MFC) begin
                        state_d = S_RUN;
                        wcnt_d  = '0;
                        advance = 1'b1;
                    end else if (wcnt_inc == WMAX) begin
                        state_d = S_FAULT;
                        nxt     = FAULT_A;
                        tout_d  = 1'b1;
                        wcnt_d  = '0;
                        advance = 1'b1;
                    end else begin
                        wcnt_d = wcnt_inc;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            upc_d = nxt;
            mw_d  = store[nxt];
        end
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q <= S_IDLE;
            upc_q   <= '0;
            mw_q    <= '0;
            wcnt_q  <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            mw_q    <= mw_d;
            wcnt_q  <= wcnt_d;
            tout_q  <= tout_d;
        end
    end

    // Same-edge fetch of ld_addr sees the old word since the write is non-blocking
    always_ff @(posedge Clk) begin
        if (ld_en && !Clr) begin
            store[ld_addr] <= ld_data;
        end
    end

    assign CW          = mw_q[CW_WIDTH-1:0];
    assign uPC         = upc_q;
    assign busy        = (state_q != S_IDLE);
    assign mem_timeout = tout_q;

endmodule
